// File: rtl/uart_cmd_decoder_if.sv
// rtl/uart_cmd_decoder_if.sv - RX FIFO pop and uart_tx start/busy handshake bundle
interface uart_cmd_decoder_if;
  logic [7:0] rx_data;
  logic [8:0] rx_count;
  logic       rx_pop;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  modport master (
    input  rx_data,
    input  rx_count,
    output rx_pop,
    output tx_data,
    output tx_start,
    input  tx_busy
  );

  modport slave (
    output rx_data,
    output rx_count,
    input  rx_pop,
    input  tx_data,
    input  tx_start,
    output tx_busy
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - 5-byte command frame parser driving an 8x8 register file
module uart_cmd_decoder #(
  parameter int         TIMEOUT   = 600000,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 resetn,
  uart_cmd_decoder_if.master   bus,
  output logic [7:0]           led,
  output logic [7:0]           err_count
);

  localparam logic [7:0]  CMD_WR     = 8'h57;
  localparam logic [7:0]  CMD_RD     = 8'h52;
  localparam logic [7:0]  RSP_ACK    = 8'h06;
  localparam logic [7:0]  RSP_NAK    = 8'h15;
  localparam logic [19:0] TIMER_LAST = 20'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_CMD,
    S_GET_ADDR,
    S_GET_DATA,
    S_GET_SUM,
    S_EXEC,
    S_RESP_WAIT,
    S_RESP_PULSE,
    S_RESP_GUARD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        pop_gap;
  logic [19:0] timer;
  logic [7:0]  cmd_q;
  logic [7:0]  addr_q;
  logic [7:0]  data_q;
  logic [7:0]  sum_q;
  logic [7:0]  regs [8];
  logic [7:0]  resp_b0;
  logic [7:0]  resp_b1;
  logic        resp_two;
  logic        resp_idx;
  logic [7:0]  tx_data_q;

  logic        consuming;
  logic        get_state;
  logic        pop;
  logic        timeout;
  logic        frame_ok;
  logic        err_inc;

  always_comb begin
    consuming = 1'b0;
    get_state = 1'b0;
    case (state)
      S_IDLE:                                     consuming = 1'b1;
      S_GET_CMD, S_GET_ADDR, S_GET_DATA, S_GET_SUM: begin
        consuming = 1'b1;
        get_state = 1'b1;
      end
      default: ;
    endcase
  end

  // rx_count lags a pop by one cycle, so every pop is followed by a dead cycle
  assign pop      = consuming && (bus.rx_count != 9'd0) && !pop_gap;
  assign timeout  = get_state && !pop && (timer == TIMER_LAST);
  assign frame_ok = (sum_q == (cmd_q ^ addr_q ^ data_q)) &&
                    ((cmd_q == CMD_WR) || (cmd_q == CMD_RD)) &&
                    (addr_q[7:3] == 5'd0);
  assign err_inc  = ((state == S_EXEC) && !frame_ok) || timeout;

  assign bus.rx_pop   = pop;
  assign bus.tx_start = (state == S_RESP_PULSE);
  assign bus.tx_data  = tx_data_q;
  assign led          = regs[0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:       if (pop && (bus.rx_data == SYNC_BYTE)) state_next = S_GET_CMD;
      S_GET_CMD:    if (pop) state_next = S_GET_ADDR; else if (timeout) state_next = S_IDLE;
      S_GET_ADDR:   if (pop) state_next = S_GET_DATA; else if (timeout) state_next = S_IDLE;
      S_GET_DATA:   if (pop) state_next = S_GET_SUM;  else if (timeout) state_next = S_IDLE;
      S_GET_SUM:    if (pop) state_next = S_EXEC;     else if (timeout) state_next = S_IDLE;
      S_EXEC:       state_next = S_RESP_WAIT;
      S_RESP_WAIT:  if (!bus.tx_busy) state_next = S_RESP_PULSE;
      S_RESP_PULSE: state_next = S_RESP_GUARD;
      // tx_busy is ignored here because uart_tx raises it a cycle after tx_start
      S_RESP_GUARD: state_next = (resp_two && !resp_idx) ? S_RESP_WAIT : S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pop_gap   <= 1'b0;
      timer     <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      sum_q     <= '0;
      resp_b0   <= '0;
      resp_b1   <= '0;
      resp_two  <= 1'b0;
      resp_idx  <= 1'b0;
      tx_data_q <= '0;
      err_count <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      pop_gap <= pop;

      if (!get_state || pop || timeout) timer <= '0;
      else                              timer <= timer + 20'd1;

      if (pop) begin
        case (state)
          S_GET_CMD:  cmd_q  <= bus.rx_data;
          S_GET_ADDR: addr_q <= bus.rx_data;
          S_GET_DATA: data_q <= bus.rx_data;
          S_GET_SUM:  sum_q  <= bus.rx_data;
          default: ;
        endcase
      end

      if (state == S_EXEC) begin
        if (frame_ok && (cmd_q == CMD_WR)) regs[addr_q[2:0]] <= data_q;
        resp_b0  <= frame_ok ? RSP_ACK : RSP_NAK;
        resp_b1  <= regs[addr_q[2:0]];
        resp_two <= frame_ok && (cmd_q == CMD_RD);
        resp_idx <= 1'b0;
      end

      if ((state == S_RESP_WAIT) && !bus.tx_busy)
        tx_data_q <= resp_idx ? resp_b1 : resp_b0;

      if (state == S_RESP_GUARD) resp_idx <= 1'b1;

      if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - directed frame tests against FIFO and uart_tx models
module tb_uart_cmd_decoder;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] led;
  logic [7:0] err_count;
  logic       force_busy = 1'b0;

  uart_cmd_decoder_if bus ();

  uart_cmd_decoder #(.TIMEOUT(100), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .led       (led),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] fifo [$];
  logic [7:0] got  [$];
  int         pops = 0;
  int         pop_b2b = 0;
  int         tx_viol = 0;
  logic       prev_pop = 1'b0;
  logic       pop_seen = 1'b0;
  logic       tx_seen  = 1'b0;
  logic [7:0] tx_seen_data = 8'h00;
  logic [7:0] last_sent = 8'h00;
  int         busy_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    pop_seen     = bus.rx_pop;
    tx_seen      = bus.tx_start;
    tx_seen_data = bus.tx_data;
    if (bus.rx_pop) begin
      pops++;
      if (prev_pop) pop_b2b++;
    end
    prev_pop = bus.rx_pop;
    if (bus.tx_start && bus.tx_busy) tx_viol++;
    if (bus.tx_busy && (busy_cnt != 0) && (bus.tx_data != last_sent)) tx_viol++;
  end

  always @(posedge clk) begin
    #1;
    if (pop_seen && fifo.size() != 0) void'(fifo.pop_front());
    if (tx_seen) begin
      got.push_back(tx_seen_data);
      last_sent = tx_seen_data;
      busy_cnt  = 6;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    bus.tx_busy  = force_busy || (busy_cnt != 0);
    bus.rx_count = 9'(fifo.size());
    bus.rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  task automatic push5(input logic [7:0] b0, b1, b2, b3, b4);
    fifo.push_back(b0); fifo.push_back(b1); fifo.push_back(b2);
    fifo.push_back(b3); fifo.push_back(b4);
  endtask

  task automatic wait_idle(input int base, input int n_resp);
    int k = 0;
    while ((fifo.size() != 0 || got.size() < base + n_resp) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check("wait_bound", 32'(k < 3000), 32'd1);
    repeat (12) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_resp(input string tag, input int base, input int n,
                            input logic [7:0] e0, input logic [7:0] e1);
    check({tag, "_nresp"}, 32'(got.size() - base), 32'(n));
    if (n > 0 && got.size() > base)     check({tag, "_rsp0"}, 32'(got[base]), 32'(e0));
    if (n > 1 && got.size() > base + 1) check({tag, "_rsp1"}, 32'(got[base + 1]), 32'(e1));
  endtask

  initial begin
    int base;
    int pbase;
    int k;
    bus.rx_data  = 8'h00;
    bus.rx_count = 9'd0;
    bus.tx_busy  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_led", 32'(led), 32'h00);
    check("rst_err", 32'(err_count), 32'h00);
    check("rst_tx_start", 32'(bus.tx_start), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_rx_pop", 32'(bus.rx_pop), 32'h0);
    resetn = 1'b1;

    base = got.size(); pbase = pops;
    push5(8'hA5, 8'h57, 8'h00, 8'h3C, 8'h6B);
    wait_idle(base, 1);
    check("w0_pops", 32'(pops - pbase), 32'd5);
    check("w0_b2b", 32'(pop_b2b), 32'd0);
    check("w0_led", 32'(led), 32'h3C);
    check_resp("w0", base, 1, 8'h06, 8'h00);
    check("w0_err", 32'(err_count), 32'd0);

    base = got.size();
    push5(8'hA5, 8'h57, 8'h03, 8'h99, 8'hCD);
    wait_idle(base, 1);
    check_resp("w3", base, 1, 8'h06, 8'h00);
    base = got.size();
    push5(8'hA5, 8'h52, 8'h03, 8'h00, 8'h51);
    wait_idle(base, 2);
    check_resp("r3", base, 2, 8'h06, 8'h99);
    check("tx_handshake", 32'(tx_viol), 32'd0);

    base = got.size();
    push5(8'hA5, 8'h57, 8'h00, 8'h3C, 8'h00);
    wait_idle(base, 1);
    check_resp("badsum", base, 1, 8'h15, 8'h00);
    check("badsum_led", 32'(led), 32'h3C);
    check("badsum_err", 32'(err_count), 32'd1);
    base = got.size();
    push5(8'hA5, 8'h57, 8'h08, 8'h00, 8'h5F);
    wait_idle(base, 1);
    check_resp("badaddr", base, 1, 8'h15, 8'h00);
    check("badaddr_err", 32'(err_count), 32'd2);

    base = got.size(); pbase = pops;
    fifo.push_back(8'h11); fifo.push_back(8'h22);
    push5(8'hA5, 8'h57, 8'h01, 8'h05, 8'h53);
    wait_idle(base, 1);
    check("garb_pops", 32'(pops - pbase), 32'd7);
    check_resp("garb", base, 1, 8'h06, 8'h00);
    base = got.size();
    push5(8'hA5, 8'h52, 8'h01, 8'h00, 8'h53);
    wait_idle(base, 2);
    check_resp("r1", base, 2, 8'h06, 8'h05);
    check("garb_err", 32'(err_count), 32'd2);

    base = got.size(); pbase = pops;
    fifo.push_back(8'hA5); fifo.push_back(8'h57);
    repeat (150) @(posedge clk);
    @(negedge clk);
    check("to_pops", 32'(pops - pbase), 32'd2);
    check("to_nresp", 32'(got.size() - base), 32'd0);
    check("to_err", 32'(err_count), 32'd3);
    base = got.size();
    push5(8'hA5, 8'h52, 8'h03, 8'h00, 8'h51);
    wait_idle(base, 2);
    check_resp("to_after", base, 2, 8'h06, 8'h99);
    check("to_after_err", 32'(err_count), 32'd3);

    push5(8'hA5, 8'h52, 8'h03, 8'h00, 8'h51);
    k = 0;
    while (!bus.tx_start && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_tx_start_seen", 32'(bus.tx_start), 32'h1);
    #1 resetn = 1'b0;
    force_busy = 1'b1;
    #1;
    check("rst_mid_tx_start", 32'(bus.tx_start), 32'h0);
    check("rst_mid_led", 32'(led), 32'h00);
    check("rst_mid_err", 32'(err_count), 32'h00);
    check("rst_mid_pop", 32'(bus.rx_pop), 32'h0);
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    repeat (10) @(posedge clk);
    base = got.size();
    push5(8'hA5, 8'h57, 8'h00, 8'h3C, 8'h6B);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("busy_hold_nresp", 32'(got.size() - base), 32'd0);
    check("busy_hold_led", 32'(led), 32'h3C);
    force_busy = 1'b0;
    wait_idle(base, 1);
    check_resp("post_rst", base, 1, 8'h06, 8'h00);
    check("post_rst_err", 32'(err_count), 32'd0);
    check("final_b2b", 32'(pop_b2b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL global_timeout: got stuck expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Downstream consumer of the RX byte FIFO in the UART loopback/bring-up design; replaces the direct FIFO-to-uart_tx path.
- Pops bytes from the FIFO head and parses 5-byte command frames.
- Executes register writes and reads on an 8x8-bit register file; register 0 drives the board LEDs.
- Emits response bytes to uart_tx using its tx_start/tx_busy handshake.

Parameters:
TIMEOUT, 600000, idle clocks allowed between bytes inside a frame (10 ms at 60 MHz); 20-bit counter.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clk  input  1  system clock (clk60 domain)
resetn  input  1  asynchronous active-low reset
rx_data  input  8  FIFO head byte (fifo dout), valid whenever rx_count != 0
rx_count  input  9  FIFO used_slots
rx_pop  output  1  one-cycle pulse; pops FIFO head (fifo shift_out)
tx_data  output  8  byte to uart_tx txdata; held stable from tx_start until tx_busy falls
tx_start  output  1  one-cycle pulse starting a uart_tx transmission
tx_busy  input  1  uart_tx busy
led  output  8  register 0 contents
err_count  output  8  saturating count of rejected or timed-out frames

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; all 8 registers 0; rx_pop=0; tx_start=0; tx_data=0; err_count=0; timer=0.
- Frame format: SYNC_BYTE, CMD, ADDR, DATA, SUM, where SUM = CMD^ADDR^DATA.
  - CMD 8'h57 ('W'): write.
  - CMD 8'h52 ('R'): read; DATA is a don't-care but is still included in SUM.
- Pop rule:
  - rx_pop asserts only in byte-consuming states (IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_SUM) and only when rx_count != 0.
  - The byte is sampled from rx_data in the same cycle rx_pop is high.
  - After a pop, one cycle with rx_pop=0 is mandatory before the next pop, because rx_count updates one cycle late.
- State machine:
  - IDLE: pop a byte. If it equals SYNC_BYTE, go to GET_CMD; otherwise discard it silently (no error count).
  - GET_CMD -> GET_ADDR -> GET_DATA -> GET_SUM: pop one byte per state and latch it.
  - GET_SUM -> EXEC: after the SUM byte is popped.
  - EXEC (1 cycle): the frame is valid only if SUM matches, CMD is 'W' or 'R', and ADDR < 8.
    - Valid 'W': reg[ADDR[2:0]] <= DATA; response = {8'h06}.
    - Valid 'R': response = {8'h06, reg[ADDR]}.
    - Invalid: response = {8'h15}; err_count increments.
    - Go to RESP.
  - RESP: for each response byte:
    - Wait for tx_busy=0, then drive tx_data and pulse tx_start for 1 cycle.
    - Ignore tx_busy for the following cycle (guard against uart_tx latency), then wait for tx_busy=0 before the next byte.
    - After the last byte's tx_start guard cycle, go to IDLE.
- Timeout:
  - The timer clears on every pop and in IDLE, EXEC and RESP.
  - The timer counts in GET_* states.
  - On reaching TIMEOUT: go to IDLE, increment err_count, send no response, and drop the partial frame.
- Pop vs timeout in the same cycle: the pop wins; the timer clears.
- err_count saturates at 8'hFF.
- A write to register 0 is visible on led the cycle after EXEC.
- An 'R' of a register takes its value at EXEC, i.e. after any earlier write.
- Bytes that arrive during RESP stay in the FIFO; nothing is popped until the FSM returns to IDLE.
- resetn asserted mid-frame or mid-response: immediate return to reset values.
  - A tx_start pulse in progress is cut.
  - uart_tx is not aborted by this block.

Test Plan:
- Write frame A5 57 00 3C 6B -> rx_pop 5 pulses, none back-to-back; led=8'h3C; single tx_start with tx_data=8'h06; err_count=0.
- Write A5 57 03 99 CD, then read A5 52 03 00 51 -> responses 06 (for the write), then 06 then 99; second tx_start only after tx_busy has fallen.
- Bad checksum A5 57 00 3C 00 -> led unchanged; response 15; err_count=1. Addr 08 with a correct sum -> 15; err_count=2.
- Garbage 11 22 then A5 57 01 05 53 -> the 2 garbage bytes are popped and discarded with no response; reg1=05; response 06.
- Send A5 57 only, then idle for TIMEOUT cycles (use TIMEOUT=100 in the bench) -> FSM back to IDLE, no tx_start, err_count+1; a following valid frame executes normally.
- Hold rx_count=0 and tx_busy=1 at reset, with resetn pulsed low mid-RESP -> tx_start=0 and led=0 immediately; next valid frame works.
